// File: rtl/audio_adc_rx.sv
// I2S receiver for the codec ADC path: oversamples BCLK/ADCLRCK/ADCDAT in the
// Clk domain, deserializes MSB-first left/right words and presents each stereo
// pair with a one-cycle sample_valid strobe.
module audio_adc_rx #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] LDATA_IN,
    output logic [DATA_WIDTH-1:0] RDATA_IN,
    output logic                  sample_valid,
    output logic                  frame_err
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StSkip, StShift, StHold} state_e;

    // [0] sync stage 1, [1] sync stage 2, [2] delay flop
    logic [2:0] bclk_sr, lrck_sr, dat_sr;

    logic bclk_rise, lrck_edge, lrck_lvl, dat;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  chan_q, chan_d;
    logic                  word_done, short_err;

    logic                  done_q, done_chan_q;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  left_ok, pair_q;

    // Two-flop synchronizers plus one delay flop per codec pin
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bclk_sr <= '0;
            lrck_sr <= '0;
            dat_sr  <= '0;
        end else begin
            bclk_sr <= {bclk_sr[1:0], AUD_BCLK};
            lrck_sr <= {lrck_sr[1:0], AUD_ADCLRCK};
            dat_sr  <= {dat_sr[1:0], AUD_ADCDAT};
        end
    end

    assign bclk_rise = bclk_sr[1] & ~bclk_sr[2];
    assign lrck_edge = lrck_sr[1] ^ lrck_sr[2];
    assign lrck_lvl  = lrck_sr[1];
    // Delayed copy keeps the data bit aligned with the edge strobes
    assign dat       = dat_sr[2];

    // Framing FSM state and shift register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            chan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
        end
    end

    // Next-state logic; an LRCK edge outranks a simultaneous BCLK rise, which
    // then serves as the skipped bit
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        word_done = 1'b0;
        short_err = 1'b0;
        if (lrck_edge && (state_q != StIdle || !lrck_lvl)) begin
            chan_d    = lrck_lvl;
            cnt_d     = '0;
            short_err = (state_q == StShift);
            state_d   = bclk_rise ? StShift : StSkip;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSkip: begin
                    if (bclk_rise) begin
                        cnt_d   = '0;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (bclk_rise) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], dat};
                        cnt_d   = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                            word_done = 1'b1;
                            state_d   = StHold;
                        end
                    end
                end
                StHold: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Word completion, left/right pairing and sticky error flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            done_q      <= 1'b0;
            done_chan_q <= 1'b0;
            left_hold   <= '0;
            left_ok     <= 1'b0;
            pair_q      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            done_q      <= word_done;
            done_chan_q <= chan_q;
            pair_q      <= 1'b0;
            if (short_err && !chan_q) begin
                left_ok <= 1'b0;
            end
            if (done_q) begin
                if (!done_chan_q) begin
                    left_hold <= shift_q;
                    left_ok   <= 1'b1;
                end else if (left_ok) begin
                    pair_q  <= 1'b1;
                    left_ok <= 1'b0;
                end
            end
            if (short_err) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Output registers; shift_q still holds the right word while HOLD lasts
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            LDATA_IN     <= '0;
            RDATA_IN     <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= pair_q;
            if (pair_q) begin
                LDATA_IN <= left_hold;
                RDATA_IN <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: drives I2S frames at BCLK = Clk/16 and
// checks decoded pairs, strobe latency, framing errors and reset behaviour.
module tb_audio_adc_rx;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        AUD_BCLK = 1'b0;
    logic        AUD_ADCLRCK = 1'b1;
    logic        AUD_ADCDAT = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] LDATA_IN, RDATA_IN;
    logic        sample_valid, frame_err;

    audio_adc_rx #(.DATA_WIDTH(16)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .err_clr      (err_clr),
        .LDATA_IN     (LDATA_IN),
        .RDATA_IN     (RDATA_IN),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          c;
        logic [15:0] l;
        logic [15:0] r;
    } pulse_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          slots;
        logic        fill;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    int          cyc = 0;
    int          lsb_cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          unstable = 0;
    pulse_t      pq[$];
    logic [15:0] prev_l = '0;
    logic [15:0] prev_r = '0;
    vec_t        tbl[4];

    always @(posedge Clk) cyc++;

    // Record every strobe and watch that outputs only move with a strobe
    always @(negedge Clk) begin
        if (sample_valid) pq.push_back('{cyc, LDATA_IN, RDATA_IN});
        if (Reset_n && !sample_valid && (LDATA_IN !== prev_l || RDATA_IN !== prev_r))
            unstable++;
        prev_l = LDATA_IN;
        prev_r = RDATA_IN;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pin changes land 2 ns after a rising Clk edge
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // One BCLK period: falling edge carries LRCK/data, then the rise
    task automatic slot(input logic lr, input logic d, input bit mark);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = d;
        tick(8);
        AUD_BCLK = 1'b1;
        if (mark) lsb_cyc = cyc + 1;
        tick(8);
    endtask

    // Slot 0 is the skipped bit, slots 1..16 carry bits 15..0, rest is fill
    task automatic send_chan(input logic lr, input logic [15:0] w, input int n,
                             input logic fill, input bit mark_lsb);
        for (int i = 0; i < n; i++) begin
            logic d;
            d = (i >= 1 && i <= 16) ? w[16-i] : fill;
            slot(lr, d, mark_lsb && i == 16);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int n,
                              input logic fill);
        send_chan(1'b0, l, n, fill, 1'b0);
        send_chan(1'b1, r, n, fill, 1'b1);
    endtask

    task automatic check_pair(input string nm, input logic [15:0] l, input logic [15:0] r);
        chk({nm, " pulses"}, pq.size(), 1);
        if (pq.size() >= 1) begin
            chk({nm, " ldata"}, {16'h0, pq[0].l}, {16'h0, l});
            chk({nm, " rdata"}, {16'h0, pq[0].r}, {16'h0, r});
            chk({nm, " latency"}, pq[0].c, lsb_cyc + 4);
        end
        pq.delete();
    endtask

    initial begin
        // Minimal I2S channel is 17 BCLK (skip slot + 16 bits); 32 is over-long
        tbl[0] = '{16'hA5C3, 16'h0F01, 17, 1'b0, 16'hA5C3, 16'h0F01};
        tbl[1] = '{16'hA5C3, 16'h0F01, 32, 1'b1, 16'hA5C3, 16'h0F01};
        tbl[2] = '{16'hFFFF, 16'h0000, 17, 1'b0, 16'hFFFF, 16'h0000};
        tbl[3] = '{16'h0001, 16'h8000, 20, 1'b1, 16'h0001, 16'h8000};

        tick(4);
        chk("reset ldata", {16'h0, LDATA_IN}, 32'h0);
        chk("reset rdata", {16'h0, RDATA_IN}, 32'h0);
        chk("reset valid", {31'h0, sample_valid}, 32'h0);
        chk("reset ferr", {31'h0, frame_err}, 32'h0);
        Reset_n = 1'b1;
        tick(4);
        chk("idle no pulse", pq.size(), 0);

        for (int v = 0; v < 4; v++) begin
            send_frame(tbl[v].l, tbl[v].r, tbl[v].slots, tbl[v].fill);
            check_pair($sformatf("vec%0d", v), tbl[v].exp_l, tbl[v].exp_r);
            chk($sformatf("vec%0d ferr", v), {31'h0, frame_err}, 32'h0);
        end

        // Streaming ramp
        for (int n = 0; n < 8; n++) send_frame(16'(n), ~16'(n), 17, 1'b0);
        chk("stream pulses", pq.size(), 8);
        for (int n = 0; n < 8 && n < pq.size(); n++) begin
            chk($sformatf("stream%0d l", n), {16'h0, pq[n].l}, {16'h0, 16'(n)});
            chk($sformatf("stream%0d r", n), {16'h0, pq[n].r}, {16'h0, ~16'(n)});
        end
        pq.delete();

        // Short word: only 10 left bits before LRCK flips
        send_chan(1'b0, 16'hFFFF, 11, 1'b0, 1'b0);
        send_chan(1'b1, 16'h7777, 17, 1'b0, 1'b0);
        chk("short ferr", {31'h0, frame_err}, 32'h1);
        chk("short no pulse", pq.size(), 0);
        pq.delete();
        send_frame(16'h1234, 16'h5678, 17, 1'b0);
        check_pair("after short", 16'h1234, 16'h5678);
        chk("ferr sticky", {31'h0, frame_err}, 32'h1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("ferr cleared", {31'h0, frame_err}, 32'h0);

        // Startup alignment: release reset part way into a right channel
        Reset_n = 1'b0;
        tick(2);
        chk("rst2 ldata", {16'h0, LDATA_IN}, 32'h0);
        for (int i = 0; i < 4; i++) slot(1'b1, 1'b1, 1'b0);
        Reset_n = 1'b1;
        for (int i = 0; i < 13; i++) slot(1'b1, i[0], 1'b0);
        chk("startup no pulse", pq.size(), 0);
        pq.delete();
        send_frame(16'h1234, 16'h5678, 17, 1'b0);
        check_pair("startup", 16'h1234, 16'h5678);

        // Reset during left bit 7
        send_chan(1'b0, 16'h9ABC, 9, 1'b0, 1'b0);
        AUD_BCLK   = 1'b0;
        AUD_ADCDAT = 1'b0;
        tick(3);
        Reset_n = 1'b0;
        #1;
        chk("midrst ldata", {16'h0, LDATA_IN}, 32'h0);
        chk("midrst rdata", {16'h0, RDATA_IN}, 32'h0);
        chk("midrst valid", {31'h0, sample_valid}, 32'h0);
        tick(4);
        Reset_n = 1'b1;
        AUD_BCLK = 1'b1;
        tick(8);
        for (int i = 6; i >= 0; i--) slot(1'b0, i[0], 1'b0);
        send_chan(1'b1, 16'h4321, 17, 1'b0, 1'b0);
        chk("midrst no pulse", pq.size(), 0);
        pq.delete();
        send_frame(16'hBEEF, 16'hCAFE, 17, 1'b0);
        check_pair("after midrst", 16'hBEEF, 16'hCAFE);

        chk("outputs stable", unstable, 0);
        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
